// File: rtl/uart_pkg.sv
// UART receiver types and timing constants derived from the shared link config.
`include "UART_config.sv"

package uart_pkg;
    localparam int DATA_W         = `WIDTH;
    localparam int CLOCKS_PER_BIT = `CLK_FREQ / `BAUD_RATE;
    localparam int HALF_BIT       = CLOCKS_PER_BIT / 2;
    localparam int BAUD_W         = $clog2(CLOCKS_PER_BIT);
    localparam int BIT_W          = $clog2(DATA_W) + 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;
endpackage

// File: rtl/UART_config.sv
// Shared UART link configuration, used by both transmit and receive sides
// so the two ends of a link always agree on bit timing.
`ifndef UART_CONFIG_SV
`define UART_CONFIG_SV
`define CLK_FREQ  1600000
`define BAUD_RATE 100000
`define WIDTH     8
`endif

// File: rtl/uart_sync.sv
// Two-flop synchronizer for a single asynchronous input; RST_VAL picks the
// value both flops take in reset (the idle level of the input).
module uart_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] ff_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) ff_q <= {2{RST_VAL}};
        else       ff_q <= {ff_q[0], d_i};
    end

    assign q_o = ff_q[1];
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling FSM feeding a hold register with a
// level valid and one-cycle read acknowledge.
module uart_rx
    import uart_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              rx,
    input  logic              read,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);
    localparam logic [BAUD_W-1:0] BIT_RELOAD  = BAUD_W'(CLOCKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] HALF_RELOAD = BAUD_W'(HALF_BIT - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT    = BIT_W'(DATA_W - 1);

    logic rx_s;

    uart_sync #(.RST_VAL(1'b1)) u_sync (
        .clk_i (clock),
        .rst_i (reset),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    rx_state_t         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;
    logic              ovr_q, ovr_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

        // Acknowledge is applied first so a same-cycle completion sees a free register.
        if (read && valid_q) valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    baud_d  = HALF_RELOAD;
                    state_d = START;
                end
            end
            START: begin
                if (baud_q == '0) begin
                    if (!rx_s) begin
                        baud_d  = BIT_RELOAD;
                        bit_d   = '0;
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            DATA: begin
                if (baud_q == '0) begin
                    shift_d = {rx_s, shift_q[DATA_W-1:1]};
                    baud_d  = BIT_RELOAD;
                    if (bit_q == LAST_BIT) state_d = STOP;
                    else                   bit_d   = bit_q + 1'b1;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            STOP: begin
                if (baud_q == '0) begin
                    if (rx_s) begin
                        state_d = IDLE;
                        if (valid_d) begin
                            ovr_d = 1'b1;
                        end else begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            WAIT_HIGH: begin
                // Hold off until the line recovers so a break is not decoded as frames.
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx with an expected-byte scoreboard.
module tb_uart_rx;
    import uart_pkg::*;

    logic              clock = 1'b0;
    logic              reset;
    logic              rx;
    logic              read;
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              frame_err;
    logic              overrun;
    logic              busy;

    int n_vec = 0;
    int n_err = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int busy_cnt = 0;
    logic [DATA_W-1:0] exp_q[$];

    localparam int NOM = CLOCKS_PER_BIT * 100;
    localparam int LAT = 2 + HALF_BIT + (DATA_W + 1) * CLOCKS_PER_BIT + 1;

    uart_rx dut (
        .clock     (clock),
        .reset     (reset),
        .rx        (rx),
        .read      (read),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (overrun)   ov_cnt <= ov_cnt + 1;
        if (busy)      busy_cnt <= busy_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one frame starting at a negedge; bit period is p100/100 cycles.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int p100);
        logic [9:0] bits;
        int elapsed;
        int target;
        bits = {stop, b, 1'b0};
        elapsed = 0;
        for (int k = 0; k < 10; k++) begin
            rx = bits[k];
            target = ((k + 1) * p100) / 100;
            repeat (target - elapsed) @(negedge clock);
            elapsed = target;
        end
    endtask

    task automatic wait_byte(input string tag);
        logic found;
        logic [DATA_W-1:0] e;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(posedge clock); #1;
            if (valid) found = 1'b1;
        end
        check({tag, "_found"}, found, 1'b1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check({tag, "_data"}, data, e);
        @(negedge clock); read = 1'b1;
        @(posedge clock); #1;
        check({tag, "_rd_clr"}, valid, 1'b0);
        @(negedge clock); read = 1'b0;
    endtask

    initial begin
        int cyc;
        int fe0, ov0, bc0;
        reset = 1'b1; rx = 1'b1; read = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_data", data, 0);
        check("rst_valid", valid, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovr", overrun, 0);
        check("rst_busy", busy, 0);
        @(negedge clock); reset = 1'b0;
        repeat (4) @(negedge clock);

        // single byte with latency measurement
        exp_q.push_back(8'hA5);
        cyc = 0;
        fork
            send_frame(8'hA5, 1'b1, NOM);
            begin
                for (int i = 0; i < 400; i++) begin
                    @(posedge clock); #1;
                    cyc++;
                    if (valid) break;
                end
            end
        join
        check("a5_latency_ok", (cyc >= LAT - 1 && cyc <= LAT + 1), 1);
        wait_byte("a5");

        // back-to-back bytes
        fe0 = fe_cnt; ov0 = ov_cnt;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        fork
            begin send_frame(8'h00, 1'b1, NOM); send_frame(8'hFF, 1'b1, NOM); end
            begin wait_byte("b2b0"); wait_byte("b2b1"); end
        join
        repeat (20) @(negedge clock);
        check("b2b_ferr", fe_cnt - fe0, 0);
        check("b2b_ovr", ov_cnt - ov0, 0);

        // glitch shorter than half a bit
        fe0 = fe_cnt; bc0 = busy_cnt;
        rx = 1'b0;
        repeat (HALF_BIT - 2) @(negedge clock);
        rx = 1'b1;
        repeat (3 * CLOCKS_PER_BIT) @(negedge clock);
        @(posedge clock); #1;
        check("glitch_busy_seen", (busy_cnt - bc0) > 0, 1);
        check("glitch_valid", valid, 0);
        check("glitch_ferr", fe_cnt - fe0, 0);
        check("glitch_idle", busy, 0);
        @(negedge clock);

        // framing error followed by a held-low line
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0, NOM);
        repeat (3 * CLOCKS_PER_BIT) @(negedge clock);
        @(posedge clock); #1;
        check("fe_pulses", fe_cnt - fe0, 1);
        check("fe_valid", valid, 0);
        check("fe_busy_low_line", busy, 1);
        @(negedge clock); rx = 1'b1;
        repeat (6) @(negedge clock);
        @(posedge clock); #1;
        check("fe_busy_released", busy, 0);
        check("fe_pulses_after", fe_cnt - fe0, 1);
        @(negedge clock);

        // overrun: second byte dropped, first byte held
        ov0 = ov_cnt;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, NOM);
        send_frame(8'h22, 1'b1, NOM);
        repeat (4) @(negedge clock);
        @(posedge clock); #1;
        check("ovr_pulses", ov_cnt - ov0, 1);
        check("ovr_valid", valid, 1);
        check("ovr_data", data, exp_q.pop_front());
        @(negedge clock);

        // read coincident with the completing stop-bit sample
        exp_q.push_back(8'h33);
        fork
            send_frame(8'h33, 1'b1, NOM);
            begin
                repeat (LAT - 1) @(negedge clock);
                read = 1'b1;
                @(negedge clock);
                read = 1'b0;
            end
        join
        @(posedge clock); #1;
        check("coll_valid", valid, 1);
        check("coll_data", data, exp_q.pop_front());
        check("coll_no_ovr", ov_cnt - ov0, 1);
        @(negedge clock);

        // reset during data bit 4 while a byte is still held
        rx = 1'b0;
        repeat (CLOCKS_PER_BIT) @(negedge clock);
        for (int k = 0; k < 4; k++) begin
            rx = k[0];
            repeat (CLOCKS_PER_BIT) @(negedge clock);
        end
        rx = 1'b1;
        repeat (HALF_BIT) @(negedge clock);
        check("pre_rst_busy", busy, 1);
        reset = 1'b1;
        @(posedge clock); #1;
        check("mid_rst_data", data, 0);
        check("mid_rst_valid", valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ferr", frame_err, 0);
        check("mid_rst_ovr", overrun, 0);
        @(negedge clock); reset = 1'b0;
        @(posedge clock); #1;
        check("post_rst_idle", busy, 0);
        repeat (4) @(negedge clock);

        // +3 % slow transmitter
        fe0 = fe_cnt;
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, NOM + (NOM * 3) / 100);
        wait_byte("skew5a");
        check("skew_ferr", fe_cnt - fe0, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
